// File: rtl/reflet_periph_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reflet_periph_arbiter_pkg
// Shared types for the two-requester peripheral bus arbiter:
//   state_e     - arbiter FSM state encoding
//   req_idx_t   - requester index (0 = CPU, 1 = secondary master)
//   burst_cnt_w - width of the burst counter for a given max_burst
// ---------------------------------------------------------------------------
package reflet_periph_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int REQ_IDX_W = 1;
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // Counter must hold 0..max_burst inclusive.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/reflet_periph_arbiter_if.sv
// ---------------------------------------------------------------------------
// Bus bundles used by reflet_periph_arbiter.
//   reflet_req_if  - one requester: req/addr/wdata/write_en in, rdata/ack out.
//                    master = requester side, slave = arbiter side.
//   reflet_pbus_if - peripheral bus: enable/addr/data_out/write_en toward the
//                    peripherals, data_in back. master = arbiter side.
// ---------------------------------------------------------------------------
interface reflet_req_if #(
    parameter int wordsize       = 16,
    parameter int base_addr_size = 16
);
    logic                      req;
    logic [base_addr_size-1:0] addr;
    logic [wordsize-1:0]       wdata;
    logic                      write_en;
    logic [wordsize-1:0]       rdata;
    logic                      ack;

    modport master (output req, addr, wdata, write_en, input rdata, ack);
    modport slave  (input req, addr, wdata, write_en, output rdata, ack);
endinterface

interface reflet_pbus_if #(
    parameter int wordsize       = 16,
    parameter int base_addr_size = 16
);
    logic                      enable;
    logic [base_addr_size-1:0] addr;
    logic [wordsize-1:0]       data_out;
    logic                      write_en;
    logic [wordsize-1:0]       data_in;

    modport master (output enable, addr, data_out, write_en, input data_in);
    modport slave  (input enable, addr, data_out, write_en, output data_in);
endinterface

// File: rtl/reflet_periph_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// reflet_rr_pick
// Combinational winner selection for the two-requester arbiter.
//   i_req0/i_req1 - live requests
//   i_last        - requester granted most recently
//   i_owner       - current bus owner
//   i_burst_cnt   - consecutive grants already given to i_last
//   o_grant       - at least one request present
//   o_winner      - requester to grant
// ---------------------------------------------------------------------------
module reflet_rr_pick
    import reflet_periph_arbiter_pkg::*;
#(
    parameter int max_burst = 4,
    parameter int CNT_W     = burst_cnt_w(max_burst)
) (
    input  logic             i_req0,
    input  logic             i_req1,
    input  req_idx_t         i_last,
    input  req_idx_t         i_owner,
    input  logic [CNT_W-1:0] i_burst_cnt,
    output logic             o_grant,
    output req_idx_t         o_winner
);

    logic w_keep;

    always_comb begin
        // The burst limit only matters on a tie; a lone requester always wins.
        // After reset owner != last, so the first tie goes to ~last (req 0).
        w_keep   = (i_burst_cnt < CNT_W'(max_burst)) && (i_last == i_owner);
        o_grant  = i_req0 | i_req1;
        o_winner = '0;
        if (i_req0 && i_req1) begin
            o_winner = w_keep ? i_last : ~i_last;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/reflet_periph_arbiter.sv
// ---------------------------------------------------------------------------
// reflet_periph_arbiter
// Shares the peripheral bus between requester 0 (CPU) and requester 1
// (secondary master). Round-robin with a bounded burst; each transaction is
// IDLE (arbitrate) -> ACCESS (bus enabled) -> RESP (ack pulse).
//   clk, reset - clock, synchronous active-high reset
//   i_m0, i_m1 - requester ports (reflet_req_if.slave)
//   o_bus      - peripheral bus (reflet_pbus_if.master); data_in is
//                combinationally valid while enable is high
// ---------------------------------------------------------------------------
module reflet_periph_arbiter
    import reflet_periph_arbiter_pkg::*;
#(
    parameter int wordsize       = 16,
    parameter int base_addr_size = 16,
    parameter int max_burst      = 4
) (
    input  logic          clk,
    input  logic          reset,
    reflet_req_if.slave   i_m0,
    reflet_req_if.slave   i_m1,
    reflet_pbus_if.master o_bus
);

    localparam int CNT_W = burst_cnt_w(max_burst);

    state_e                    r_state, w_state_nxt;
    req_idx_t                  r_owner, w_owner_nxt;
    req_idx_t                  r_last, w_last_nxt;
    req_idx_t                  w_winner;
    logic [CNT_W-1:0]          r_burst_cnt, w_burst_nxt;
    logic [wordsize-1:0]       r_m0_rdata, r_m1_rdata;
    logic                      w_grant;
    logic                      w_access;
    logic [base_addr_size-1:0] w_addr;
    logic [wordsize-1:0]       w_dout;
    logic                      w_we;

    reflet_rr_pick #(
        .max_burst (max_burst),
        .CNT_W     (CNT_W)
    ) u_pick (
        .i_req0      (i_m0.req),
        .i_req1      (i_m1.req),
        .i_last      (r_last),
        .i_owner     (r_owner),
        .i_burst_cnt (r_burst_cnt),
        .o_grant     (w_grant),
        .o_winner    (w_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_last      <= '1;
            r_burst_cnt <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_nxt;
            // Read data is sampled at the end of the single ACCESS cycle.
            if (w_access && !w_we) begin
                if (r_owner == '0) r_m0_rdata <= o_bus.data_in;
                else               r_m1_rdata <= o_bus.data_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ACCESS;
                    w_owner_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    if (w_winner != r_last)
                        w_burst_nxt = CNT_W'(1);
                    else if (r_burst_cnt < CNT_W'(max_burst))
                        w_burst_nxt = r_burst_cnt + CNT_W'(1);
                end else begin
                    w_burst_nxt = '0;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus is driven only in ACCESS; every other cycle it reads as all zero.
    assign w_access = (r_state == ST_ACCESS);

    always_comb begin
        w_addr = '0;
        w_dout = '0;
        w_we   = 1'b0;
        if (w_access) begin
            if (r_owner == '0) begin
                w_addr = i_m0.addr;
                w_dout = i_m0.wdata;
                w_we   = i_m0.write_en;
            end else begin
                w_addr = i_m1.addr;
                w_dout = i_m1.wdata;
                w_we   = i_m1.write_en;
            end
        end
    end

    assign o_bus.enable   = w_access;
    assign o_bus.addr     = w_addr;
    assign o_bus.data_out = w_dout;
    assign o_bus.write_en = w_we;

    assign i_m0.ack   = (r_state == ST_RESP) && (r_owner == '0);
    assign i_m1.ack   = (r_state == ST_RESP) && (r_owner != '0);
    assign i_m0.rdata = r_m0_rdata;
    assign i_m1.rdata = r_m1_rdata;

endmodule

// File: tb/tb_reflet_periph_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for reflet_periph_arbiter. Two instances: g_dut[0] with max_burst=4,
// g_dut[1] with max_burst=1. Requesters are modelled as transaction queues;
// a transaction-level reference predicts the grant order and every cycle of
// bus, ack and rdata activity.
// ---------------------------------------------------------------------------
module tb_reflet_periph_arbiter;

    localparam int W = 16;
    localparam int A = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        t_req   [2][2];
    logic [15:0] t_addr  [2][2];
    logic [15:0] t_wdata [2][2];
    logic        t_we    [2][2];
    logic        o_ack   [2][2];
    logic [15:0] o_rdata [2][2];
    logic        o_en    [2];
    logic [15:0] o_addr  [2];
    logic [15:0] o_dout  [2];
    logic        o_bwe   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_prev [2];
    int          m_run  [2];
    logic [15:0] m_rdata[2][2];
    txn_t        tq0[$];
    txn_t        tq1[$];

    // Peripheral read data as a function of the address on the bus.
    function automatic logic [15:0] periph_rd(input logic [15:0] a);
        return (a == 16'hFF05) ? 16'h1234 : (a ^ 16'hA5C3);
    endfunction

    function automatic int mb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        reflet_req_if  #(.wordsize(W), .base_addr_size(A)) m0_if ();
        reflet_req_if  #(.wordsize(W), .base_addr_size(A)) m1_if ();
        reflet_pbus_if #(.wordsize(W), .base_addr_size(A)) bus_if ();

        assign m0_if.req      = t_req[g][0];
        assign m0_if.addr     = t_addr[g][0];
        assign m0_if.wdata    = t_wdata[g][0];
        assign m0_if.write_en = t_we[g][0];
        assign m1_if.req      = t_req[g][1];
        assign m1_if.addr     = t_addr[g][1];
        assign m1_if.wdata    = t_wdata[g][1];
        assign m1_if.write_en = t_we[g][1];
        assign o_ack[g][0]    = m0_if.ack;
        assign o_ack[g][1]    = m1_if.ack;
        assign o_rdata[g][0]  = m0_if.rdata;
        assign o_rdata[g][1]  = m1_if.rdata;
        assign bus_if.data_in = periph_rd(bus_if.addr);
        assign o_en[g]        = bus_if.enable;
        assign o_addr[g]      = bus_if.addr;
        assign o_dout[g]      = bus_if.data_out;
        assign o_bwe[g]       = bus_if.write_en;

        reflet_periph_arbiter #(
            .wordsize       (W),
            .base_addr_size (A),
            .max_burst      ((g == 0) ? 4 : 1)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .i_m0  (m0_if),
            .i_m1  (m1_if),
            .o_bus (bus_if)
        );
    end

    task automatic drive_req(input int d, input int r, input bit act, input txn_t t);
        t_req[d][r]   = act;
        t_addr[d][r]  = act ? t.addr  : 16'h0;
        t_wdata[d][r] = act ? t.wdata : 16'h0;
        t_we[d][r]    = act ? t.we    : 1'b0;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.addr  = ($urandom_range(0, 7) == 0) ? 16'hFF05 : 16'($urandom);
        t.wdata = 16'($urandom);
        t.we    = 1'($urandom_range(0, 1));
        return t;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_prev[d] = 0;
            m_run[d]  = 0;
            m_rdata[d][0] = 16'h0;
            m_rdata[d][1] = 16'h0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Runs tq0/tq1 to completion on instance d, checking every cycle.
    task automatic test_run(input int d, input string nm);
        int   n [2];
        int   h [2];
        int   w, run, prev, nb;
        int   wins[$];
        txn_t cur;
        txn_t z;
        logic        e_en, e_we, e_ack0, e_ack1;
        logic [15:0] e_addr, e_dout;
        z = '0;
        n[0] = tq0.size();
        n[1] = tq1.size();
        nb   = mb(d);
        run  = m_run[d];
        prev = m_prev[d];
        h    = '{0, 0};
        // Grant order: while both are pending, a requester keeps the bus for
        // up to nb consecutive grants, then the other one gets it.
        while (h[0] < n[0] || h[1] < n[1]) begin
            if (h[0] < n[0] && h[1] < n[1]) w = (run < nb) ? prev : 1 - prev;
            else                            w = (h[0] < n[0]) ? 0 : 1;
            run  = (w == prev) ? ((run < nb) ? run + 1 : nb) : 1;
            prev = w;
            wins.push_back(w);
            h[w]++;
        end
        h = '{0, 0};
        foreach (wins[k]) begin
            w   = wins[k];
            cur = (w == 0) ? tq0[h[0]] : tq1[h[1]];
            for (int p = 0; p < 3; p++) begin
                @(posedge clk); #1;
                if (h[0] < n[0]) drive_req(d, 0, 1'b1, tq0[h[0]]); else drive_req(d, 0, 1'b0, z);
                if (h[1] < n[1]) drive_req(d, 1, 1'b1, tq1[h[1]]); else drive_req(d, 1, 1'b0, z);
                @(negedge clk);
                e_en   = (p == 1);
                e_addr = (p == 1) ? cur.addr  : 16'h0;
                e_dout = (p == 1) ? cur.wdata : 16'h0;
                e_we   = (p == 1) && cur.we;
                e_ack0 = (p == 2) && (w == 0);
                e_ack1 = (p == 2) && (w == 1);
                if (p == 2 && !cur.we) m_rdata[d][w] = periph_rd(cur.addr);
                n_checks++;
                if (o_en[d] !== e_en) begin
                    n_fail++;
                    $display("FAIL %s.enable d=%0d slot=%0d ph=%0d got=%b exp=%b", nm, d, k, p, o_en[d], e_en);
                end
                n_checks++;
                if (o_addr[d] !== e_addr) begin
                    n_fail++;
                    $display("FAIL %s.addr d=%0d slot=%0d ph=%0d got=%h exp=%h", nm, d, k, p, o_addr[d], e_addr);
                end
                n_checks++;
                if (o_dout[d] !== e_dout) begin
                    n_fail++;
                    $display("FAIL %s.data_out d=%0d slot=%0d ph=%0d got=%h exp=%h", nm, d, k, p, o_dout[d], e_dout);
                end
                n_checks++;
                if (o_bwe[d] !== e_we) begin
                    n_fail++;
                    $display("FAIL %s.write_en d=%0d slot=%0d ph=%0d got=%b exp=%b", nm, d, k, p, o_bwe[d], e_we);
                end
                n_checks++;
                if (o_ack[d][0] !== e_ack0) begin
                    n_fail++;
                    $display("FAIL %s.m0_ack d=%0d slot=%0d ph=%0d got=%b exp=%b", nm, d, k, p, o_ack[d][0], e_ack0);
                end
                n_checks++;
                if (o_ack[d][1] !== e_ack1) begin
                    n_fail++;
                    $display("FAIL %s.m1_ack d=%0d slot=%0d ph=%0d got=%b exp=%b", nm, d, k, p, o_ack[d][1], e_ack1);
                end
                n_checks++;
                if (o_rdata[d][0] !== m_rdata[d][0]) begin
                    n_fail++;
                    $display("FAIL %s.m0_rdata d=%0d slot=%0d ph=%0d got=%h exp=%h", nm, d, k, p, o_rdata[d][0], m_rdata[d][0]);
                end
                n_checks++;
                if (o_rdata[d][1] !== m_rdata[d][1]) begin
                    n_fail++;
                    $display("FAIL %s.m1_rdata d=%0d slot=%0d ph=%0d got=%h exp=%h", nm, d, k, p, o_rdata[d][1], m_rdata[d][1]);
                end
            end
            h[w]++;
        end
        // Requests drop; this IDLE cycle has no request, so the burst count clears.
        @(posedge clk); #1;
        drive_req(d, 0, 1'b0, z);
        drive_req(d, 1, 1'b0, z);
        m_run[d]  = 0;
        m_prev[d] = prev;
        tq0.delete();
        tq1.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_en[d] !== 1'b0 || o_bwe[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset.en_we d=%0d got=%b%b exp=00", d, o_en[d], o_bwe[d]);
            end
            n_checks++;
            if (o_addr[d] !== 16'h0 || o_dout[d] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset.addr_data d=%0d got=%h/%h exp=0000/0000", d, o_addr[d], o_dout[d]);
            end
            for (int r = 0; r < 2; r++) begin
                n_checks++;
                if (o_ack[d][r] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset.ack d=%0d r=%0d got=%b exp=0", d, r, o_ack[d][r]);
                end
                n_checks++;
                if (o_rdata[d][r] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL reset.rdata d=%0d r=%0d got=%h exp=0000", d, r, o_rdata[d][r]);
                end
            end
        end
        #1;
        do_reset();
    endtask

    task automatic test_single_read();
        tq0.push_back('{addr: 16'hFF05, wdata: 16'h0000, we: 1'b0});
        test_run(0, "m0_read");
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (o_rdata[0][0] !== 16'h1234 || o_ack[0][1] !== 1'b0) begin
                n_fail++;
                $display("FAIL m0_read.hold got rdata=%h m1_ack=%b exp 1234/0", o_rdata[0][0], o_ack[0][1]);
            end
        end
    endtask

    task automatic test_write_m1();
        tq1.push_back('{addr: 16'hFF0B, wdata: 16'h00A5, we: 1'b1});
        test_run(0, "m1_write");
    endtask

    task automatic test_burst4();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tq0.push_back(rand_txn());
            tq1.push_back(rand_txn());
        end
        test_run(0, "burst4");
    endtask

    task automatic test_burst1();
        for (int i = 0; i < 5; i++) begin
            tq0.push_back(rand_txn());
            tq1.push_back(rand_txn());
        end
        test_run(1, "alt1");
        for (int i = 0; i < 3; i++) tq0.push_back(rand_txn());
        test_run(1, "m0_only");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int d;
            int n0;
            int n1;
            d  = it % 2;
            n0 = $urandom_range(0, 6);
            n1 = $urandom_range(0, 6);
            for (int i = 0; i < n0; i++) tq0.push_back(rand_txn());
            for (int i = 0; i < n1; i++) tq1.push_back(rand_txn());
            test_run(d, "random");
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        txn_t z;
        z = '0;
        tq0.push_back('{addr: 16'hFF05, wdata: 16'h0000, we: 1'b0});
        test_run(0, "pre_reset_read");
        t = '{addr: 16'h0042, wdata: 16'h0000, we: 1'b0};
        @(posedge clk); #1;
        drive_req(0, 0, 1'b1, t);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_en[0] !== 1'b1 || o_addr[0] !== 16'h0042) begin
            n_fail++;
            $display("FAIL rst_mid.access got en=%b addr=%h exp 1/0042", o_en[0], o_addr[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive_req(0, 0, 1'b0, z);
        model_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_en[0] !== 1'b0 || o_addr[0] !== 16'h0) begin
                n_fail++;
                $display("FAIL rst_mid.bus c=%0d got en=%b addr=%h exp 0/0000", c, o_en[0], o_addr[0]);
            end
            n_checks++;
            if (o_ack[0][0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid.m0_ack c=%0d got=%b exp=0", c, o_ack[0][0]);
            end
            n_checks++;
            if (o_rdata[0][0] !== 16'h0) begin
                n_fail++;
                $display("FAIL rst_mid.m0_rdata c=%0d got=%h exp=0000", c, o_rdata[0][0]);
            end
            @(posedge clk); #1;
        end
        tq1.push_back('{addr: 16'h0077, wdata: 16'h0000, we: 1'b0});
        test_run(0, "post_reset_m1");
    endtask

    // m1 raises req while m0 is in ACCESS; it must wait for the next IDLE.
    task automatic test_late_m1();
        logic [15:0] e_addr [7] = '{16'h0, 16'h0010, 16'h0, 16'h0, 16'hFF0B, 16'h0, 16'h0};
        logic [15:0] e_dout [7] = '{16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h3C3C, 16'h0, 16'h0};
        logic        e_en   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        e_we   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        e_ack0 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        e_ack1 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        txn_t z;
        z = '0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive_req(0, 0, 1'b1, '{addr: 16'h0010, wdata: 16'hBEEF, we: 1'b0});
            if (c == 1) drive_req(0, 1, 1'b1, '{addr: 16'hFF0B, wdata: 16'h3C3C, we: 1'b1});
            if (c == 3) drive_req(0, 0, 1'b0, z);
            if (c == 6) drive_req(0, 1, 1'b0, z);
            @(negedge clk);
            if (c == 2) m_rdata[0][0] = periph_rd(16'h0010);
            n_checks++;
            if (o_en[0] !== e_en[c] || o_bwe[0] !== e_we[c]) begin
                n_fail++;
                $display("FAIL late_m1.en_we c=%0d got=%b%b exp=%b%b", c, o_en[0], o_bwe[0], e_en[c], e_we[c]);
            end
            n_checks++;
            if (o_addr[0] !== e_addr[c] || o_dout[0] !== e_dout[c]) begin
                n_fail++;
                $display("FAIL late_m1.addr_data c=%0d got=%h/%h exp=%h/%h", c, o_addr[0], o_dout[0], e_addr[c], e_dout[c]);
            end
            n_checks++;
            if (o_ack[0][0] !== e_ack0[c] || o_ack[0][1] !== e_ack1[c]) begin
                n_fail++;
                $display("FAIL late_m1.acks c=%0d got=%b%b exp=%b%b", c, o_ack[0][0], o_ack[0][1], e_ack0[c], e_ack1[c]);
            end
            n_checks++;
            if (o_rdata[0][0] !== m_rdata[0][0] || o_rdata[0][1] !== m_rdata[0][1]) begin
                n_fail++;
                $display("FAIL late_m1.rdata c=%0d got=%h/%h exp=%h/%h", c, o_rdata[0][0], o_rdata[0][1], m_rdata[0][0], m_rdata[0][1]);
            end
        end
        m_prev[0] = 1;
        m_run[0]  = 0;
    endtask

    initial begin
        txn_t z;
        z = '0;
        reset = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 2; r++)
                drive_req(d, r, 1'b0, z);
        model_reset();
        test_reset();
        test_single_read();
        test_write_m1();
        test_burst4();
        test_burst1();
        test_random();
        test_reset_mid();
        test_late_m1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reflet_periph_arbiter.md
Name: reflet_periph_arbiter

Overview:
Two-requester arbiter that shares the memory-mapped peripheral bus (enable/addr/data/write_en) between the CPU (requester 0) and a secondary master such as a DMA engine (requester 1).
- Sits between the masters and the peripheral aggregate.
- Serialises accesses with a req/ack handshake.
- Round-robin arbitration with a bounded burst length, so neither master starves the other.

Parameters:
wordsize, 16, data width of all buses
base_addr_size, 16, address width of all buses
max_burst, 4, max consecutive grants to one requester while the other is requesting (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
m0_req  input  1  requester 0 transaction request (level)
m0_addr  input  base_addr_size  requester 0 address
m0_wdata  input  wordsize  requester 0 write data
m0_write_en  input  1  requester 0 write (1) / read (0)
m0_rdata  output  wordsize  requester 0 read data
m0_ack  output  1  requester 0 completion pulse
m1_req, m1_addr, m1_wdata, m1_write_en, m1_rdata, m1_ack  same as m0_* for requester 1
enable  output  1  peripheral bus enable
addr  output  base_addr_size  peripheral bus address
data_out  output  wordsize  write data to peripherals
write_en  output  1  peripheral write strobe
data_in  input  wordsize  read data from peripherals, combinationally valid during the enable cycle

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. All state updates on rising clk.
- Reset values:
  - state=IDLE, owner=0, last=1 (requester 0 wins the first tie), burst_cnt=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
  - enable=write_en=0, addr=0, data_out=0.
- Reset mid-transaction aborts it: no ack issued, bus deasserted the following cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE (arbitration):
  - No req: stay IDLE, burst_cnt=0.
  - One req: grant it.
  - Both req: grant `last` if burst_cnt<max_burst and last==owner; otherwise grant ~last.
  - On grant:
    - owner<=winner.
    - burst_cnt<=(winner==last)?burst_cnt+1:1.
    - last<=winner.
    - Go to ACCESS.
  - burst_cnt saturates at max_burst.
  - When only one requester is active, burst_cnt still counts but never blocks the grant.
- ACCESS:
  - enable=1; addr/data_out/write_en are combinational muxes of the owner's inputs.
  - Read: owner's rdata register captures data_in at the end of this cycle.
  - Write: write_en is high for exactly this one cycle.
  - Always go to RESP.
- RESP:
  - owner's ack=1 for one cycle; the other ack=0.
  - rdata stays valid from this cycle until the next read completion for that requester. Writes leave rdata unchanged.
  - Always go to IDLE.
- Bus idle value: outside ACCESS, enable=write_en=0 and addr=data_out=0.
- Latency: req sampled high in an IDLE cycle T → enable at T+1 → ack at T+2. Minimum 3 cycles per transaction; a queued other requester is granted at T+3.
- Requester rules:
  - Hold req, addr, wdata and write_en stable from raising req until the ack cycle, inclusive.
  - req may stay high after ack to issue a back-to-back transaction; new addr/data must be stable from the cycle after ack.
  - Dropping req before ack is illegal; the arbiter still completes the transaction.
- Fairness: with both requesters continuously active and max_burst=N, the grant pattern is N×A, N×B, … After reset: N×m0, N×m1, repeat.
- Simultaneous events: a newly raised req during ACCESS/RESP waits for the next IDLE. It never preempts an in-flight access.

Decomposition:
- Shared package constants:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Requester index width (1 bit).
- One natural sub-module: reflet_rr_pick, the combinational winner selection from (req0, req1, last, burst_cnt, max_burst).
- FSM, muxes and capture registers stay in the top module.

Test Plan:
- Reset then single m0 read, addr=16'hFF05, data_in=16'h1234 during enable → enable high exactly at T+1 with addr=FF05, write_en=0; m0_ack pulses at T+2; m0_rdata=1234 held afterwards; m1_ack never asserts.
- m1 write, addr=FF0B, wdata=00A5 → single-cycle enable+write_en with data_out=00A5 at T+1; m1_ack at T+2; m1_rdata unchanged.
- Both req raised in the same IDLE cycle after reset, held continuously, max_burst=4 → ack sequence m0,m0,m0,m0,m1,m1,m1,m1,m0…; every transaction spans exactly 3 cycles.
- max_burst=1, both active → strict alternation m0,m1,m0,m1; only m0 active → back-to-back m0 acks every 3 cycles with no idle gap beyond IDLE.
- Reset asserted during ACCESS of an m0 read → no m0_ack; next cycle enable=0, m0_rdata=0, state IDLE; a subsequent m1 request is granted normally.
- m1 raises req during m0's ACCESS → m0 completes undisturbed; m1 gets enable 1 cycle after the IDLE following m0_ack; bus outputs are all zero in every non-ACCESS cycle.
